// File: rtl/muldiv_iterativo_pkg.sv
`default_nettype none
//============================================================================
// Package : muldiv_iterativo_pkg
// Op codes, FSM states and default widths of the iterative mul/div unit.
// Rev     : 1.0
//============================================================================
package muldiv_iterativo_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_UDIV = 2'b01,
    MD_SDIV = 2'b10,
    MD_RSVD = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_paso.sv
`default_nettype none
//============================================================================
// Module : muldiv_paso
// One radix-2 iteration: shift-add multiply or restoring-divide step.
// Rev    : 1.0
//============================================================================
module muldiv_paso #(
  parameter int WIDTH = 32
) (
  input  logic             mul,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] x_n,
  output logic [WIDTH-1:0] y_n
);

  logic [WIDTH:0]   w_rem_sh;
  logic             w_fits;
  logic [WIDTH-1:0] w_diff;

  // Divide: acc = partial remainder, x = divisor, y = dividend shifting into quotient.
  // Multiply: acc = partial product, x = multiplicand, y = multiplier.
  always_comb begin
    w_rem_sh = {acc, y[WIDTH-1]};
    w_fits   = (w_rem_sh >= {1'b0, x});
    w_diff   = w_rem_sh[WIDTH-1:0] - x;
    if (mul) begin
      acc_n = acc + (y[0] ? x : '0);
      x_n   = x << 1;
      y_n   = y >> 1;
    end else begin
      acc_n = w_fits ? w_diff : w_rem_sh[WIDTH-1:0];
      x_n   = x;
      y_n   = {y[WIDTH-2:0], w_fits};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_iterativo.sv
`default_nettype none
//============================================================================
// Module : muldiv_iterativo
// Radix-2 iterative multiply/divide unit driving register-bank write-back.
// Rev    : 1.0
//============================================================================
module muldiv_iterativo
  import muldiv_iterativo_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              div0,
  output logic              bad_op,
  output logic [WIDTH-1:0]  wd3,
  output logic [ADDR_W-1:0] a3,
  output logic              we3_n
);

  localparam int               c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  md_state_t           r_state;
  md_state_t           w_state_nxt;
  md_op_t              r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]    r_acc;
  logic [WIDTH-1:0]    r_x;
  logic [WIDTH-1:0]    r_y;
  logic [WIDTH-1:0]    r_result;
  logic                r_neg;
  logic                r_div0;
  logic                r_bad;

  logic                w_accept;
  logic                w_is_div;
  logic                w_b_zero;
  logic                w_early;
  logic [WIDTH-1:0]    w_abs_a;
  logic [WIDTH-1:0]    w_abs_b;
  logic [WIDTH-1:0]    w_acc_n;
  logic [WIDTH-1:0]    w_x_n;
  logic [WIDTH-1:0]    w_y_n;

  always_comb begin
    w_accept = (r_state == ST_IDLE) && start;
    w_is_div = (op == MD_UDIV) || (op == MD_SDIV);
    w_b_zero = (b == '0);
    w_early  = (op == MD_RSVD) || (w_is_div && w_b_zero);
    w_abs_a  = ((op == MD_SDIV) && a[WIDTH-1]) ? -a : a;
    w_abs_b  = ((op == MD_SDIV) && b[WIDTH-1]) ? -b : b;
  end

  muldiv_paso #(
    .WIDTH (WIDTH)
  ) u_paso (
    .mul   (r_op == MD_MUL),
    .acc   (r_acc),
    .x     (r_x),
    .y     (r_y),
    .acc_n (w_acc_n),
    .x_n   (w_x_n),
    .y_n   (w_y_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    we3_n       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = w_early ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_cnt == c_LAST) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        we3_n       = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= MD_MUL;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_div0   <= 1'b0;
      r_bad    <= 1'b0;
    end else if (w_accept) begin
      r_op     <= md_op_t'(op);
      r_addr   <= rd_addr;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_x      <= w_is_div ? w_abs_b : a;
      r_y      <= w_is_div ? w_abs_a : b;
      r_result <= '0;
      r_neg    <= (op == MD_SDIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_div0   <= w_is_div && w_b_zero;
      r_bad    <= (op == MD_RSVD);
    end else if (r_state == ST_CALC) begin
      r_acc <= w_acc_n;
      r_x   <= w_x_n;
      r_y   <= w_y_n;
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == ST_FIX) begin
      // Divide leaves the quotient in r_y; the product accumulates in r_acc.
      if (r_neg) begin
        r_result <= -r_y;
      end else begin
        r_result <= (r_op == MD_MUL) ? r_acc : r_y;
      end
    end
  end

  assign result = r_result;
  assign wd3    = r_result;
  assign a3     = r_addr;
  assign div0   = r_div0;
  assign bad_op = r_bad;

endmodule
`default_nettype wire
